// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared constants and FSM state type for the instruction loader
package program_loader_pkg;
  localparam logic [3:0] CMD_NIBBLE = 4'b1010;
  localparam int SLOTS = 4;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CHECK} state_t;
endpackage

// File: rtl/program_loader_word_assembler.sv
// program_loader_word_assembler: packs big-endian bytes into words, flags the completing byte
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_valid
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);
  localparam int SH_W = 8 * (BYTES_PER_WORD - 1);
  logic [CNT_W-1:0] cnt;
  logic [SH_W-1:0] sh;
  assign word_valid = en && cnt == CNT_W'(BYTES_PER_WORD - 1);
  assign word = {sh, din};
  // shift in bytes, MSB first; counter restarts whenever the frame leaves the data phase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sh <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      sh <= {sh[SH_W-9:0], din};
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: framed byte stream to instruction RAM slot writer with checksum
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int SLOT_WORDS = 1024
) (
  input  logic                  Fast_Clock,
  input  logic                  Reset_n,
  input  logic [7:0]            In_Data,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [DATA_WIDTH-1:0] Mem_Data,
  output logic                  Mem_Write,
  output logic                  Hold_CPU,
  output logic                  Load_Done,
  output logic                  Load_Error
);
  localparam int IDX_W = $clog2(SLOT_WORDS);
  localparam int SLOT_W = $clog2(SLOTS);
  state_t state;
  logic [7:0] cnt_hi, chk;
  logic [SLOT_W-1:0] slot;
  logic [IDX_W-1:0] idx, last_idx;
  logic [15:0] n;
  logic [31:0] word;
  logic accept, word_valid;
  assign accept = In_Valid && In_Ready;
  assign n = {cnt_hi, In_Data};
  assign Hold_CPU = state != IDLE;
  program_loader_word_assembler u_wa (
    .clk(Fast_Clock),
    .rst_n(Reset_n),
    .clear(state != DATA),
    .en(accept && state == DATA),
    .din(In_Data),
    .word(word),
    .word_valid(word_valid)
  );
  // frame FSM: command decode, count check, word writes, checksum verdict
  always_ff @(posedge Fast_Clock or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      In_Ready <= 1'b0;
      Mem_Addr <= '0;
      Mem_Data <= '0;
      Mem_Write <= 1'b0;
      Load_Done <= 1'b0;
      Load_Error <= 1'b0;
      cnt_hi <= '0;
      chk <= '0;
      slot <= '0;
      idx <= '0;
      last_idx <= '0;
    end else begin
      In_Ready <= 1'b1;
      Mem_Write <= 1'b0;
      Load_Done <= 1'b0;
      Load_Error <= 1'b0;
      if (word_valid) begin
        Mem_Write <= 1'b1;
        Mem_Data <= DATA_WIDTH'(word);
        Mem_Addr <= ADDR_WIDTH'({slot, idx});
        idx <= idx + 1'b1;
        if (idx == last_idx) state <= CHECK;
      end
      if (accept)
        case (state)
          IDLE:
            if (In_Data[7:2] == {CMD_NIBBLE, 2'b00}) begin
              slot <= In_Data[SLOT_W-1:0];
              chk <= '0;
              idx <= '0;
              state <= CNT_HI;
            end
          CNT_HI: begin
            cnt_hi <= In_Data;
            state <= CNT_LO;
          end
          CNT_LO:
            if (n == 16'd0 || n > 16'(SLOT_WORDS)) begin
              Load_Error <= 1'b1;
              state <= IDLE;
            end else begin
              last_idx <= IDX_W'(n - 16'd1);
              state <= DATA;
            end
          DATA: chk <= chk ^ In_Data;
          CHECK: begin
            Load_Done <= chk == In_Data;
            Load_Error <= chk != In_Data;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for the instruction loader
module tb_program_loader;
  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [7:0] In_Data = '0;
  logic In_Valid = 1'b0;
  logic In_Ready, Mem_Write, Hold_CPU, Load_Done, Load_Error;
  logic [12:0] Mem_Addr;
  logic [31:0] Mem_Data;
  int n_checks = 0, n_err = 0;
  int exp_done = 0, exp_err = 0, act_done = 0, act_err = 0;
  bit gap_mode = 0;
  logic [44:0] exp_q[$];
  logic [31:0] words[$];

  program_loader dut (
    .Fast_Clock(clk),
    .Reset_n(Reset_n),
    .In_Data(In_Data),
    .In_Valid(In_Valid),
    .In_Ready(In_Ready),
    .Mem_Addr(Mem_Addr),
    .Mem_Data(Mem_Data),
    .Mem_Write(Mem_Write),
    .Hold_CPU(Hold_CPU),
    .Load_Done(Load_Done),
    .Load_Error(Load_Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk)
    if (Reset_n) begin
      if (Mem_Write) begin
        if (exp_q.size() == 0) check("unexpected_write", {51'd0, Mem_Addr}, 64'h1fff_ffff);
        else begin
          logic [44:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {51'd0, Mem_Addr}, {51'd0, e[44:32]});
          check("wr_data", {32'd0, Mem_Data}, {32'd0, e[31:0]});
        end
      end
      if (Load_Done) begin
        act_done++;
        check("hold_at_done", {63'd0, Hold_CPU}, 64'd0);
      end
      if (Load_Error) begin
        act_err++;
        check("hold_at_err", {63'd0, Hold_CPU}, 64'd0);
      end
    end

  task automatic send(input logic [7:0] b);
    if (gap_mode && $urandom_range(0, 2) == 0) begin
      In_Valid = 1'b0;
      @(posedge clk);
      #1;
    end
    In_Valid = 1'b1;
    In_Data = b;
    @(posedge clk);
    #1;
    In_Valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] n, input logic [7:0] flip);
    logic [7:0] chk, b;
    logic [31:0] w;
    logic [12:0] a;
    chk = '0;
    send(cmd);
    check("hold_after_cmd", {63'd0, Hold_CPU}, 64'd1);
    send(n[15:8]);
    send(n[7:0]);
    if (n == 0 || n > 1024) begin
      exp_err++;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      w = words[i];
      a = 13'(cmd[1:0]) * 13'd1024 + 13'(i);
      exp_q.push_back({a, w});
      for (int k = 3; k >= 0; k--) begin
        b = w[k*8+:8];
        chk ^= b;
        send(b);
      end
    end
    send(chk ^ flip);
    if (flip != 0) exp_err++;
    else exp_done++;
  endtask

  task automatic settle(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done"}, 64'(act_done), 64'(exp_done));
    check({tag, "_err"}, 64'(act_err), 64'(exp_err));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, {63'd0, Hold_CPU}, 64'd0);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic check_reset_outs(input string tag, input logic ready);
    check({tag, "_ready"}, {63'd0, In_Ready}, {63'd0, ready});
    check({tag, "_addr"}, {51'd0, Mem_Addr}, 64'd0);
    check({tag, "_data"}, {32'd0, Mem_Data}, 64'd0);
    check({tag, "_flags"}, {60'd0, Mem_Write, Hold_CPU, Load_Done, Load_Error}, 64'd0);
  endtask

  initial begin
    #7;
    check_reset_outs("rst", 1'b0);
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", {63'd0, In_Ready}, 64'd1);

    words.delete();
    words.push_back(32'h1234_5678);
    words.push_back(32'hDEAD_BEEF);
    send_frame(8'hA1, 16'd2, 8'h00);
    settle("slot1_ok");
    send_frame(8'hA1, 16'd2, 8'h2A);
    settle("slot1_badchk");

    rand_words(3);
    send_frame(8'hA3, 16'h0000, 8'h00);
    send_frame(8'hA3, 16'h0401, 8'h00);
    send_frame(8'hA2, 16'd3, 8'h00);
    settle("badcnt");

    send(8'h55);
    send(8'hFF);
    check("garbage_idle", {63'd0, Hold_CPU}, 64'd0);
    words.delete();
    words.push_back(32'hCAFE_F00D);
    send_frame(8'hA0, 16'd1, 8'h00);
    settle("garbage");

    gap_mode = 1;
    rand_words(5);
    send_frame(8'hA2, 16'd5, 8'h00);
    settle("gaps");
    gap_mode = 0;

    rand_words(1024);
    send_frame(8'hA3, 16'd1024, 8'h00);
    settle("full");
    check("full_last_addr", {51'd0, Mem_Addr}, 64'd4095);

    send(8'hA1);
    send(8'h00);
    send(8'h01);
    send(8'h11);
    send(8'h22);
    Reset_n = 1'b0;
    #1;
    check_reset_outs("abort", 1'b0);
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk);
    #1;
    words.delete();
    words.push_back(32'h0BAD_F00D);
    send_frame(8'hA1, 16'd1, 8'h00);
    settle("after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
